// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types and scoreboard sizing constants
package lc3b_types;

  localparam int LC3B_NUM_REGS   = 8;
  localparam int SB_MAX_INFLIGHT = 4;
  localparam int SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);

  typedef logic [2:0]          lc3b_reg;
  typedef logic [SB_CNT_W-1:0] lc3b_sb_cnt;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - up/down in-flight counter with clear and underflow detect
module sb_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nz,
  output logic         underflow
);

  // Simultaneous inc and dec cancel; the caller guarantees inc never hits a saturated count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign nz        = (cnt != '0);
  assign underflow = dec && !inc && !clr && (cnt == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - LC-3b decode issue scoreboard; HAZARD_WB_BYPASS_EN enables same-cycle retire bypass
module hazard_scoreboard
  import lc3b_types::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [2:0]       dec_src_a,
  input  logic             dec_src_a_used,
  input  logic [2:0]       dec_src_b,
  input  logic             dec_src_b_used,
  input  logic             dec_reads_cc,
  input  logic [2:0]       dec_dr,
  input  logic             dec_writes_dr,
  input  logic             dec_sets_cc,
  input  logic             issue_ready,
  input  logic             wb_valid,
  input  logic [2:0]       wb_dr,
  input  logic             wb_writes_dr,
  input  logic             wb_sets_cc,
  input  logic             flush,
  output logic             issue,
  output logic             stall,
  output logic [7:0]       busy_regs,
  output logic             cc_busy,
  output logic [CNT_W-1:0] inflight,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]         reg_cnt [LC3B_NUM_REGS];
  logic [LC3B_NUM_REGS-1:0] reg_nz, reg_inc, reg_dec, reg_uf, reg_busy;
  logic [CNT_W-1:0]         cc_cnt, tot_cnt;
  logic                     cc_nz, cc_inc, cc_dec, cc_uf, cc_hz_busy;
  logic                     tot_nz, tot_dec, tot_uf, tot_full;
  logic                     hazard;

  // Retires arriving during a flush are squashed along with everything else.
  assign cc_inc  = issue && dec_sets_cc;
  assign cc_dec  = wb_valid && wb_sets_cc && !flush;
  assign tot_dec = wb_valid && !flush;

  for (genvar g = 0; g < LC3B_NUM_REGS; g++) begin : g_reg
    assign reg_inc[g] = issue && dec_writes_dr && (dec_dr == lc3b_reg'(g));
    assign reg_dec[g] = wb_valid && wb_writes_dr && !flush && (wb_dr == lc3b_reg'(g));

    sb_counter #(.W(CNT_W)) u_reg_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (reg_inc[g]),
      .dec       (reg_dec[g]),
      .clr       (flush),
      .cnt       (reg_cnt[g]),
      .nz        (reg_nz[g]),
      .underflow (reg_uf[g])
    );

`ifdef HAZARD_WB_BYPASS_EN
    assign reg_busy[g] = reg_nz[g] && !((reg_cnt[g] == CNT_ONE) && reg_dec[g]);
`else
    assign reg_busy[g] = reg_nz[g];
`endif
  end

  sb_counter #(.W(CNT_W)) u_cc_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (cc_inc),
    .dec       (cc_dec),
    .clr       (flush),
    .cnt       (cc_cnt),
    .nz        (cc_nz),
    .underflow (cc_uf)
  );

  sb_counter #(.W(CNT_W)) u_tot_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue),
    .dec       (tot_dec),
    .clr       (flush),
    .cnt       (tot_cnt),
    .nz        (tot_nz),
    .underflow (tot_uf)
  );

`ifdef HAZARD_WB_BYPASS_EN
  assign cc_hz_busy = cc_nz && !((cc_cnt == CNT_ONE) && cc_dec);
  assign tot_full   = (tot_cnt == CNT_MAX) && !tot_dec;
`else
  assign cc_hz_busy = cc_nz;
  assign tot_full   = (tot_cnt == CNT_MAX);
`endif

  assign hazard = (dec_src_a_used && reg_busy[dec_src_a])
                | (dec_src_b_used && reg_busy[dec_src_b])
                | (dec_reads_cc   && cc_hz_busy)
                | (dec_writes_dr  && (reg_cnt[dec_dr] == CNT_MAX))
                | (dec_sets_cc    && (cc_cnt == CNT_MAX))
                | tot_full;

  assign issue = dec_valid && issue_ready && !hazard && !flush && !rst;
  assign stall = dec_valid && !issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if ((|reg_uf) || cc_uf || tot_uf) begin
      sb_err <= 1'b1;
    end
  end

  assign busy_regs = reg_nz;
  assign cc_busy   = cc_nz;
  assign inflight  = tot_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid = 0, dec_src_a_used = 0, dec_src_b_used = 0, dec_reads_cc = 0;
  logic [2:0] dec_src_a = 0, dec_src_b = 0, dec_dr = 0, wb_dr = 0;
  logic       dec_writes_dr = 0, dec_sets_cc = 0, issue_ready = 0;
  logic       wb_valid = 0, wb_writes_dr = 0, wb_sets_cc = 0, flush = 0;
  logic       issue, stall, cc_busy, sb_err;
  logic [7:0] busy_regs;
  logic [2:0] inflight;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src_a(dec_src_a),
    .dec_src_a_used(dec_src_a_used), .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used),
    .dec_reads_cc(dec_reads_cc), .dec_dr(dec_dr), .dec_writes_dr(dec_writes_dr),
    .dec_sets_cc(dec_sets_cc), .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_dr(wb_dr),
    .wb_writes_dr(wb_writes_dr), .wb_sets_cc(wb_sets_cc), .flush(flush), .issue(issue),
    .stall(stall), .busy_regs(busy_regs), .cc_busy(cc_busy), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer occupancy per resource.
  int m_cnt [8];
  int m_cc, m_tot;
  bit m_err;
  bit last_iss;

  typedef struct { logic [2:0] dr; bit w; bit c; } rec_t;
  rec_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int i);
    if (m_cnt[i] == 0) return 0;
`ifdef HAZARD_WB_BYPASS_EN
    if (m_cnt[i] == 1 && wb_valid && wb_writes_dr && int'(wb_dr) == i) return 0;
`endif
    return 1;
  endfunction

  function automatic bit m_issue();
    bit hz = 0;
    int tot_eff = m_tot;
    bit cc_b = (m_cc != 0);
`ifdef HAZARD_WB_BYPASS_EN
    if (m_cc == 1 && wb_valid && wb_sets_cc) cc_b = 0;
    if (wb_valid) tot_eff = tot_eff - 1;
`endif
    if (dec_src_a_used && m_busy(int'(dec_src_a))) hz = 1;
    if (dec_src_b_used && m_busy(int'(dec_src_b))) hz = 1;
    if (dec_reads_cc && cc_b) hz = 1;
    if (dec_writes_dr && m_cnt[dec_dr] == MAX) hz = 1;
    if (dec_sets_cc && m_cc == MAX) hz = 1;
    if (tot_eff >= MAX) hz = 1;
    return dec_valid && issue_ready && !hz && !flush && !rst;
  endfunction

  function automatic int nxt(input int c, input bit inc, input bit dec);
    if (inc && !dec) return c + 1;
    if (dec && !inc) begin
      if (c == 0) begin
        m_err = 1;
        return 0;
      end
      return c - 1;
    end
    return c;
  endfunction

  task automatic m_update(input bit iss);
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_cc = 0; m_tot = 0; m_err = 0;
    end else if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_cc = 0; m_tot = 0;
    end else begin
      foreach (m_cnt[i])
        m_cnt[i] = nxt(m_cnt[i], iss && dec_writes_dr && int'(dec_dr) == i,
                       wb_valid && wb_writes_dr && int'(wb_dr) == i);
      m_cc  = nxt(m_cc, iss && dec_sets_cc, wb_valid && wb_sets_cc);
      m_tot = nxt(m_tot, iss, wb_valid);
    end
  endtask

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    foreach (m_cnt[i]) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  // Inputs are set after a falling edge; outputs are compared 1 time unit later.
  task automatic cycle();
    #1;
    last_iss = m_issue();
    chk("issue", issue, last_iss);
    chk("stall", stall, dec_valid && !last_iss);
    chk("busy_regs", busy_regs, m_busy_vec());
    chk("cc_busy", cc_busy, m_cc != 0);
    chk("inflight", inflight, m_tot);
    chk("sb_err", sb_err, m_err);
    @(posedge clk);
    m_update(last_iss);
    @(negedge clk);
  endtask

  task automatic set_dec(input bit v, input int sa, input bit sau, input int sb, input bit sbu,
                         input bit rcc, input int dr, input bit wdr, input bit scc);
    dec_valid = v; dec_src_a = 3'(sa); dec_src_a_used = sau; dec_src_b = 3'(sb);
    dec_src_b_used = sbu; dec_reads_cc = rcc; dec_dr = 3'(dr); dec_writes_dr = wdr; dec_sets_cc = scc;
  endtask

  task automatic set_wb(input bit v, input int dr, input bit w, input bit c);
    wb_valid = v; wb_dr = 3'(dr); wb_writes_dr = w; wb_sets_cc = c;
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_cc = 0; m_tot = 0; m_err = 0;
    rst = 1; dec_valid = 1;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_busy", busy_regs, 8'h00);
    chk("rst_inflight", inflight, 0);
    rst = 0; issue_ready = 1;

    // RAW on R3
    set_dec(1, 0, 0, 0, 0, 0, 3, 1, 0); cycle();
    set_dec(1, 3, 1, 1, 1, 0, 4, 1, 0); cycle(); cycle();
    chk("raw_stall", stall, 1);
    set_wb(1, 3, 1, 0); cycle();
`ifdef HAZARD_WB_BYPASS_EN
    chk("raw_retire_cycle", last_iss, 1);
    set_wb(0, 0, 0, 0); set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
`else
    chk("raw_retire_cycle", last_iss, 0);
    set_wb(0, 0, 0, 0); cycle();
    chk("raw_after_retire", last_iss, 1);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_wb(1, 4, 1, 0); cycle(); set_wb(0, 0, 0, 0);

    // CC hazard: LD R2 then BR
    set_dec(1, 0, 0, 0, 0, 0, 2, 1, 1); cycle();
    set_dec(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle(); cycle();
    chk("cc_busy_set", cc_busy, 1);
    set_wb(1, 2, 1, 1); cycle(); set_wb(0, 0, 0, 0);
    chk("cc_busy_clear", cc_busy, 0);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Full pipeline
    rst = 1; cycle(); rst = 0;
    foreach (m_cnt[i]) if (i == 1 || i == 2 || i == 4 || i == 5) begin
      set_dec(1, 0, 0, 0, 0, 0, i, 1, 0); cycle();
    end
    chk("full_inflight", inflight, MAX);
    set_dec(1, 0, 0, 0, 0, 0, 6, 1, 0); cycle();
    chk("full_stall", stall, 1);
    set_wb(1, 1, 1, 0); cycle(); set_wb(0, 0, 0, 0);
    if (!last_iss) cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 2, 1, 0); cycle();
    set_wb(1, 4, 1, 0); cycle();
    set_wb(1, 5, 1, 0); cycle(); set_wb(0, 0, 0, 0);

    // Same-register issue and retire on R6
    chk("r6_pre_busy", busy_regs, 8'h40);
    set_dec(1, 0, 0, 0, 0, 0, 6, 1, 0); set_wb(1, 6, 1, 0); cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0); set_wb(0, 0, 0, 0);
    chk("r6_same_busy", busy_regs, 8'h40);
    chk("r6_same_inflight", inflight, 1);
    set_wb(1, 6, 1, 0); cycle(); set_wb(0, 0, 0, 0);

    // Flush then underflow
    for (int r = 1; r <= 3; r++) begin
      set_dec(1, 0, 0, 0, 0, 0, r, 1, 0); cycle();
    end
    chk("pre_flush_inflight", inflight, 3);
    flush = 1; set_wb(1, 1, 1, 0); cycle();
    chk("flush_issue", last_iss, 0);
    flush = 0; set_wb(0, 0, 0, 0); set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("flush_inflight", inflight, 0);
    set_wb(1, 2, 1, 0); cycle(); set_wb(0, 0, 0, 0);
    chk("underflow_err", sb_err, 1);
    cycle(); cycle();
    chk("err_sticky", sb_err, 1);
    rst = 1; cycle(); rst = 0;
    chk("err_cleared", sb_err, 0);

    // Randomized traffic with retires drawn from the issued stream
    q.delete();
    for (int n = 0; n < 400; n++) begin
      bit from_q = 0;
      rst   = ($urandom_range(99) == 0);
      flush = ($urandom_range(29) == 0);
      issue_ready = ($urandom_range(9) < 8);
      set_dec($urandom_range(9) < 8, $urandom_range(7), $urandom_range(1), $urandom_range(7),
              $urandom_range(1), $urandom_range(3) == 0, $urandom_range(7), $urandom_range(3) != 0,
              $urandom_range(2) == 0);
      if (q.size() != 0 && $urandom_range(9) < 4) begin
        set_wb(1, q[0].dr, q[0].w, q[0].c); from_q = 1;
      end else if ($urandom_range(39) == 0) begin
        set_wb(1, $urandom_range(7), $urandom_range(1), $urandom_range(1));
      end else begin
        set_wb(0, 0, 0, 0);
      end
      cycle();
      if (rst || flush) q.delete();
      else begin
        if (from_q) void'(q.pop_front());
        if (last_iss) q.push_back('{dr: dec_dr, w: dec_writes_dr, c: dec_sets_cc});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
